// File: rtl/rx_pkg.sv
// Shared types and default sizing for the USB receive bit-unstuffing path.
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STUFF = 2'd2
    } state_t;

    localparam int STUFF_LEN_DEF = 6;
    localparam int BYTE_W_DEF    = 8;

endpackage

// File: rtl/rx_bit_counter.sv
// Data-bit position counter: counts enabled cycles and wraps to 0 on reaching rollover_val.
module rx_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             count_enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] rollover_val,
    output logic [CNT_W-1:0] count,
    output logic             rollover_flag
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Flag marks the enabled cycle that takes the last position; the count wraps on that edge.
    always_comb begin
        rollover_flag = !clear && count_enable && (count_q == rollover_val - 1'b1);
        count_d       = count_q;
        if (clear || rollover_flag) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rx_unstuff_shift.sv
// Removes USB stuffed zeros from the decoded bit stream and assembles LSB-first bytes,
// flagging missing stuff bits and end-of-packet on a partial byte.
module rx_unstuff_shift
    import rx_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF,
    parameter int BYTE_W    = BYTE_W_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rcv_enable,
    input  logic              d_orig,
    input  logic              shift_enable,
    input  logic              eop,
    input  logic              clear,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              byte_valid,
    output logic              stuff_error,
    output logic              align_error
);

    localparam int CNT_W  = $clog2(BYTE_W + 1);
    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam logic [CNT_W-1:0]  ROLL_VAL = CNT_W'(BYTE_W);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);

    state_t              state_q, state_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [BYTE_W-1:0]   shreg_q, shreg_d;
    logic [BYTE_W-1:0]   rx_byte_q, rx_byte_d;
    logic                byte_valid_q, byte_valid_d;
    logic                stuff_error_q, stuff_error_d;
    logic                align_error_q, align_error_d;

    logic                sample_ok;
    logic                bit_en;
    logic                bit_clr;
    logic [CNT_W-1:0]    bit_cnt;
    logic                bit_roll;

    // A strobe that survives the higher-priority clear / disable / IDLE conditions.
    assign sample_ok = rcv_enable && !clear && (state_q != IDLE) && shift_enable;
    assign bit_en    = sample_ok && !eop && (state_q == DATA);
    assign bit_clr   = clear || !rcv_enable || (state_q == IDLE)
                     || (sample_ok && eop)
                     || (sample_ok && (state_q == STUFF) && d_orig);

    rx_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk           (clk),
        .n_rst         (n_rst),
        .count_enable  (bit_en),
        .clear         (bit_clr),
        .rollover_val  (ROLL_VAL),
        .count         (bit_cnt),
        .rollover_flag (bit_roll)
    );

    always_comb begin
        // NOTE: every output gets a default before the branches so no latch is inferred.
        state_d       = state_q;
        ones_d        = ones_q;
        shreg_d       = shreg_q;
        rx_byte_d     = rx_byte_q;
        byte_valid_d  = 1'b0;
        stuff_error_d = 1'b0;
        align_error_d = 1'b0;

        if (clear) begin
            ones_d  = '0;
            shreg_d = '0;
            state_d = rcv_enable ? DATA : IDLE;
        end else if (!rcv_enable) begin
            ones_d  = '0;
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            ones_d  = '0;
            state_d = DATA;
        end else if (shift_enable && eop) begin
            ones_d        = '0;
            state_d       = DATA;
            align_error_d = (bit_cnt != '0);
        end else if (shift_enable && state_q == DATA) begin
            shreg_d = {d_orig, shreg_q[BYTE_W-1:1]};
            if (d_orig) begin
                ones_d = ones_q + 1'b1;
                if (ones_q + 1'b1 == ONES_MAX) begin
                    state_d = STUFF;
                end
            end else begin
                ones_d = '0;
            end
            if (bit_roll) begin
                rx_byte_d    = {d_orig, shreg_q[BYTE_W-1:1]};
                byte_valid_d = 1'b1;
            end
        end else if (shift_enable && state_q == STUFF) begin
            // The stuff bit itself is never shifted; a 1 here means the byte is lost.
            ones_d        = '0;
            state_d       = DATA;
            stuff_error_d = d_orig;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            ones_q        <= '0;
            shreg_q       <= '0;
            rx_byte_q     <= '0;
            byte_valid_q  <= 1'b0;
            stuff_error_q <= 1'b0;
            align_error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q       <= state_d;
            ones_q        <= ones_d;
            shreg_q       <= shreg_d;
            rx_byte_q     <= rx_byte_d;
            byte_valid_q  <= byte_valid_d;
            stuff_error_q <= stuff_error_d;
            align_error_q <= align_error_d;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign byte_valid  = byte_valid_q;
    assign stuff_error = stuff_error_q;
    assign align_error = align_error_q;

endmodule

// File: tb/tb_rx_unstuff_shift.sv
// Bench for rx_unstuff_shift: directed scenarios plus a long random stream, all checked
// against a queue-based model of the unstuffing rules.
module tb_rx_unstuff_shift;

    localparam int STUFF_LEN = 6;
    localparam int BYTE_W    = 8;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              rcv_enable;
    logic              d_orig;
    logic              shift_enable;
    logic              eop;
    logic              clear;
    logic [BYTE_W-1:0] rx_byte;
    logic              byte_valid;
    logic              stuff_error;
    logic              align_error;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit                m_active;
    bit                m_bits[$];
    int                m_run;
    bit                m_expect_stuff;
    logic [BYTE_W-1:0] m_rx_byte;

    // Pulses observed from the DUT since the last zeroing
    int n_valid, n_stuff, n_align;

    rx_unstuff_shift #(
        .STUFF_LEN (STUFF_LEN),
        .BYTE_W    (BYTE_W)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .rcv_enable   (rcv_enable),
        .d_orig       (d_orig),
        .shift_enable (shift_enable),
        .eop          (eop),
        .clear        (clear),
        .rx_byte      (rx_byte),
        .byte_valid   (byte_valid),
        .stuff_error  (stuff_error),
        .align_error  (align_error)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
    task automatic step(input logic rst_i, input logic clr_i, input logic rcv_i,
                        input logic se_i, input logic eop_i, input logic d_i);
        bit e_bv, e_se, e_ae;
        e_bv = 0; e_se = 0; e_ae = 0;
        n_rst = rst_i; clear = clr_i; rcv_enable = rcv_i;
        shift_enable = se_i; eop = eop_i; d_orig = d_i;
        @(posedge clk);
        if (!rst_i) begin
            m_active = 0; m_bits.delete(); m_run = 0; m_expect_stuff = 0; m_rx_byte = '0;
        end else if (clr_i) begin
            m_active = rcv_i; m_bits.delete(); m_run = 0; m_expect_stuff = 0;
        end else if (!rcv_i) begin
            m_active = 0; m_bits.delete(); m_run = 0; m_expect_stuff = 0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (se_i && eop_i) begin
            e_ae = (m_bits.size() != 0);
            m_bits.delete(); m_run = 0; m_expect_stuff = 0;
        end else if (se_i) begin
            if (m_expect_stuff) begin
                m_expect_stuff = 0;
                m_run = 0;
                if (d_i) begin
                    e_se = 1;
                    m_bits.delete();
                end
            end else begin
                m_bits.push_back(d_i);
                m_run = d_i ? m_run + 1 : 0;
                if (m_run == STUFF_LEN) m_expect_stuff = 1;
                if (m_bits.size() == BYTE_W) begin
                    for (int i = 0; i < BYTE_W; i++) m_rx_byte[i] = m_bits[i];
                    e_bv = 1;
                    m_bits.delete();
                end
            end
        end
        #1;
        total += 5;
        if (byte_valid !== e_bv) begin
            bad++; $display("FAIL byte_valid t=%0t got=%b want=%b", $time, byte_valid, e_bv);
        end
        if (stuff_error !== e_se) begin
            bad++; $display("FAIL stuff_error t=%0t got=%b want=%b", $time, stuff_error, e_se);
        end
        if (align_error !== e_ae) begin
            bad++; $display("FAIL align_error t=%0t got=%b want=%b", $time, align_error, e_ae);
        end
        if (rx_byte !== m_rx_byte) begin
            bad++; $display("FAIL rx_byte t=%0t got=%h want=%h", $time, rx_byte, m_rx_byte);
        end
        if ((32'(byte_valid) + 32'(stuff_error) + 32'(align_error)) > 1) begin
            bad++; $display("FAIL pulse_exclusive t=%0t bv=%b se=%b ae=%b",
                            $time, byte_valid, stuff_error, align_error);
        end
        if (byte_valid === 1'b1)  n_valid++;
        if (stuff_error === 1'b1) n_stuff++;
        if (align_error === 1'b1) n_align++;
    endtask

    task automatic send_bit(input logic d, input int gap);
        for (int g = 0; g < gap; g++) step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0, d);
    endtask

    task automatic send_byte(input logic [BYTE_W-1:0] b, input int gap);
        for (int i = 0; i < BYTE_W; i++) send_bit(b[i], gap);
    endtask

    task automatic zero_counts();
        n_valid = 0; n_stuff = 0; n_align = 0;
    endtask

    task automatic check_counts(input string name, input int v, input int s, input int a);
        total++;
        if (n_valid != v || n_stuff != s || n_align != a) begin
            bad++;
            $display("FAIL %s pulses got v=%0d s=%0d a=%0d want v=%0d s=%0d a=%0d",
                     name, n_valid, n_stuff, n_align, v, s, a);
        end
    endtask

    task automatic check_byte(input string name, input logic [BYTE_W-1:0] want);
        total++;
        if (rx_byte !== want) begin
            bad++; $display("FAIL %s rx_byte got=%h want=%h", name, rx_byte, want);
        end
    endtask

    task automatic test_reset();
        zero_counts();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 1);
        check_byte("reset", 8'h00);
        check_counts("reset", 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);   // IDLE -> DATA
    endtask

    task automatic test_no_stuff();
        logic [BYTE_W-1:0] pat;
        pat = 8'b0000_0101;
        zero_counts();
        send_byte(pat, 0);
        check_byte("no_stuff", 8'h05);
        check_counts("no_stuff", 1, 0, 0);
    endtask

    task automatic test_stuff_ok();
        zero_counts();
        for (int i = 0; i < 6; i++) send_bit(1, 0);
        send_bit(0, 0);
        send_bit(1, 0);
        send_bit(1, 0);
        check_byte("stuff_ok", 8'hFF);
        check_counts("stuff_ok", 1, 0, 0);
    endtask

    task automatic test_stuff_boundary();
        zero_counts();
        send_byte(8'hFC, 0);      // six ones end exactly on the last data bit
        check_byte("stuff_boundary", 8'hFC);
        send_bit(0, 0);           // stuffed zero must be dropped
        send_byte(8'h00, 0);
        check_byte("stuff_boundary_next", 8'h00);
        check_counts("stuff_boundary", 2, 0, 0);
    endtask

    task automatic test_stuff_error();
        zero_counts();
        for (int i = 0; i < 7; i++) send_bit(1, 0);
        check_counts("stuff_error", 0, 1, 0);
        send_byte(8'h5A, 0);
        check_byte("stuff_error_next", 8'h5A);
        check_counts("stuff_error_next", 1, 1, 0);
    endtask

    task automatic test_align();
        zero_counts();
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
        step(1, 0, 1, 1, 1, 0);
        check_counts("align", 0, 0, 1);
        send_byte(8'hA5, 0);
        check_byte("align_next", 8'hA5);
        step(1, 0, 1, 1, 1, 1);   // eop on a byte boundary: no error
        check_counts("align_boundary", 1, 0, 1);
    endtask

    task automatic test_clear_reset();
        zero_counts();
        send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
        step(1, 1, 1, 1, 0, 1);   // clear together with a strobe
        send_byte(8'h3C, 0);
        check_byte("clear_next", 8'h3C);
        check_counts("clear", 1, 0, 0);
        zero_counts();
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
        step(0, 0, 1, 1, 0, 1);
        step(1, 0, 1, 0, 0, 0);
        check_byte("mid_reset", 8'h00);
        check_counts("mid_reset", 0, 0, 0);
        send_byte(8'h81, 0);
        check_byte("after_reset", 8'h81);
    endtask

    task automatic test_gaps();
        zero_counts();
        send_byte(8'h6E, 20);
        check_byte("gaps", 8'h6E);
        for (int i = 0; i < 6; i++) send_bit(1, 20);
        send_bit(0, 20);
        send_bit(1, 20);
        send_bit(1, 20);
        check_byte("gaps_stuff", 8'hFF);
        check_counts("gaps", 2, 0, 0);
    endtask

    task automatic test_random();
        int r;
        logic clr_i, rcv_i, eop_i, d_i;
        zero_counts();
        for (int n = 0; n < 3000; n++) begin
            r     = int'($urandom_range(0, 199));
            clr_i = (r == 0);
            rcv_i = !(r == 1 || r == 2);
            eop_i = (r >= 3 && r < 8);
            d_i   = ($urandom_range(0, 9) < 8);
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) step(1, 0, 1, 0, 0, 0);
            step(1, clr_i, rcv_i, 1, eop_i, d_i);
        end
        total++;
        if (n_valid == 0 || n_stuff == 0) begin
            bad++; $display("FAIL random_coverage got v=%0d s=%0d want both nonzero", n_valid, n_stuff);
        end
    endtask

    initial begin
        n_rst = 0; rcv_enable = 0; d_orig = 0; shift_enable = 0; eop = 0; clear = 0;
        test_reset();
        test_no_stuff();
        test_stuff_ok();
        test_stuff_boundary();
        test_stuff_error();
        test_align();
        test_clear_reset();
        test_gaps();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
